// File: rtl/vsssp_apply.sv
// ---------------------------------------------------------------------------
// vsssp_apply
//
// Apply stage of one processing element in a level-synchronous shortest-path
// (BFS style) engine. It is the source side of the vsssp message interface;
// the gather stage downstream is the sink.
//
// On a start pulse the block walks its node-state memory from node 0 up to
// NUM_NODES-1. For every node whose active flag is set it emits one message
// {sender = node ID, dist = saturating dist+1, level = latched level}. When
// that message is accepted it clears the node's active flag through the write
// port. At the end of the walk it pulses done and reports via any_sent whether
// this level produced any message, which feeds the global level barrier.
//
// Optional feature (macro VSSSP_APPLY_STATS_EN):
//   When defined, adds output msg_count, the number of messages accepted in
//   the current or most recent level. When undefined, the port and the
//   counter are absent and everything else behaves identically.
//
// Ports:
//   sys_clk          in   rising-edge clock
//   sys_rst_n        in   asynchronous active-low reset
//   start            in   one-cycle pulse, begins a scan (accepted in IDLE only)
//   level_in[31:0]   in   level number, latched on an accepted start
//   state_rd_addr    out  state memory read address
//   state_rd_en      out  read strobe; memory returns data one cycle later
//   state_rd_dist    in   stored distance of the addressed node
//   state_rd_active  in   stored active flag of the addressed node
//   state_wr_en      out  clear-active write strobe
//   state_wr_addr    out  clear-active write address
//   msg_valid        out  message valid
//   msg_ack          in   consumer accepts the message (when msg_valid=1)
//   msg_sender[31:0] out  sending node ID, zero-extended
//   msg_dist[7:0]    out  proposed distance (saturates at 8'hFF)
//   msg_level[31:0]  out  latched level
//   busy             out  scan in progress (READ/EVAL/SEND)
//   done             out  one-cycle pulse at the end of a scan
//   any_sent         out  a message was accepted this level; held until next start
//   msg_count        out  (VSSSP_APPLY_STATS_EN only) messages accepted this level
//   o_dbg_state[2:0] out  current FSM state encoding, for checkers
//
// Message handshake: msg_valid is asserted for the whole SEND state and the
// msg_* payload is frozen while msg_valid is high. A transfer happens in the
// cycle where msg_valid && msg_ack; msg_valid drops in the following cycle.
// msg_ack has no effect while msg_valid is low. At most one message is ever
// outstanding.
// ---------------------------------------------------------------------------
module vsssp_apply #(
    parameter int NUM_NODES  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [31:0]           level_in,
    output logic [ADDR_WIDTH-1:0] state_rd_addr,
    output logic                  state_rd_en,
    input  logic [7:0]            state_rd_dist,
    input  logic                  state_rd_active,
    output logic                  state_wr_en,
    output logic [ADDR_WIDTH-1:0] state_wr_addr,
    output logic                  msg_valid,
    input  logic                  msg_ack,
    output logic [31:0]           msg_sender,
    output logic [7:0]            msg_dist,
    output logic [31:0]           msg_level,
    output logic                  busy,
    output logic                  done,
    output logic                  any_sent,
`ifdef VSSSP_APPLY_STATS_EN
    output logic [ADDR_WIDTH:0]   msg_count,
`endif
    output logic [2:0]            o_dbg_state
);

    // Highest node ID owned by this PE; the address counter stops here.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EVAL = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_level;
    logic [31:0]             r_msg_sender;
    logic [7:0]              r_msg_dist;
    logic [31:0]             r_msg_level;
    logic                    r_any_sent;
`ifdef VSSSP_APPLY_STATS_EN
    logic [ADDR_WIDTH:0]     r_msg_count;
`endif

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    state_t                  w_next_state;
    logic                    w_start_acc;   // start accepted (IDLE only)
    logic                    w_load_msg;    // active node found in EVAL
    logic                    w_advance;     // current node finished
    logic                    w_accept;      // message transfer this cycle
    logic                    w_last;        // current node is the last one
    logic [7:0]              w_dist_inc;    // saturating dist+1

    assign w_last      = (r_addr == LAST_ADDR);
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_SEND) && msg_ack;

    // Distance is an 8-bit quantity; an unreachable-looking FF must not wrap
    // back to 0, so the increment pins at FF.
    assign w_dist_inc  = (state_rd_dist == 8'hFF) ? 8'hFF : (state_rd_dist + 8'd1);

    always_comb begin
        w_next_state = r_state;
        w_load_msg   = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                // Read strobe is issued here; data shows up during EVAL.
                w_next_state = ST_EVAL;
            end
            ST_EVAL: begin
                if (state_rd_active) begin
                    w_load_msg   = 1'b1;
                    w_next_state = ST_SEND;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_SEND: begin
                if (msg_ack) begin
                    w_advance    = 1'b1;
                    w_next_state = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                // A start in this cycle is deliberately not looked at.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Address counter and latched level
    // The counter only advances when the current node is not the last one,
    // so it never goes past NUM_NODES-1 and never wraps.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr  <= '0;
            r_level <= '0;
        end else if (w_start_acc) begin
            r_addr  <= '0;
            r_level <= level_in;
        end else if (w_advance && !w_last) begin
            r_addr  <= r_addr + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Message payload. Loaded once per active node in EVAL and untouched
    // through SEND, which keeps it stable for the whole valid window.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_msg_sender <= '0;
            r_msg_dist   <= '0;
            r_msg_level  <= '0;
        end else if (w_load_msg) begin
            r_msg_sender <= {{(32-ADDR_WIDTH){1'b0}}, r_addr};
            r_msg_dist   <= w_dist_inc;
            r_msg_level  <= r_level;
        end
    end

    // -----------------------------------------------------------------------
    // Level summary: any_sent is cleared on an accepted start and set by the
    // first transfer; it then holds until the next accepted start.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_any_sent <= 1'b0;
        end else if (w_start_acc) begin
            r_any_sent <= 1'b0;
        end else if (w_accept) begin
            r_any_sent <= 1'b1;
        end
    end

`ifdef VSSSP_APPLY_STATS_EN
    // At most NUM_NODES transfers per level, which fits ADDR_WIDTH+1 bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_msg_count <= '0;
        end else if (w_start_acc) begin
            r_msg_count <= '0;
        end else if (w_accept) begin
            r_msg_count <= r_msg_count + 1'b1;
        end
    end

    assign msg_count = r_msg_count;
`endif

    // -----------------------------------------------------------------------
    // Outputs. Strobes decode directly from the state register so they are
    // all 0 while reset holds the FSM in IDLE.
    // -----------------------------------------------------------------------
    assign state_rd_addr = r_addr;
    assign state_rd_en   = (r_state == ST_READ);
    // The clear-active write coincides with the transfer cycle, so a message
    // dropped by reset leaves its node active for the next scan.
    assign state_wr_en   = w_accept;
    assign state_wr_addr = r_addr;
    assign msg_valid     = (r_state == ST_SEND);
    assign msg_sender    = r_msg_sender;
    assign msg_dist      = r_msg_dist;
    assign msg_level     = r_msg_level;
    assign busy          = (r_state == ST_READ) || (r_state == ST_EVAL) ||
                           (r_state == ST_SEND);
    assign done          = (r_state == ST_DONE);
    assign any_sent      = r_any_sent;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_vsssp_apply.sv
// ---------------------------------------------------------------------------
// Testbench for vsssp_apply, built with NUM_NODES=4.
// A behavioural state memory drives the read port and applies the clear-active
// writes. Before each scan the expected message list is derived straight from
// the memory contents (every active node in ID order, dist+1 saturating,
// latched level) and pushed to an expected queue that a monitor drains.
// ---------------------------------------------------------------------------
module tb_vsssp_apply;

  localparam int NN = 4;
  localparam int AW = 2;

  // ---------------------------------------------------------------- signals
  logic          sys_clk;
  logic          sys_rst_n;
  logic          start;
  logic [31:0]   level_in;
  logic [AW-1:0] state_rd_addr;
  logic          state_rd_en;
  logic [7:0]    state_rd_dist;
  logic          state_rd_active;
  logic          state_wr_en;
  logic [AW-1:0] state_wr_addr;
  logic          msg_valid;
  logic          msg_ack;
  logic [31:0]   msg_sender;
  logic [7:0]    msg_dist;
  logic [31:0]   msg_level;
  logic          busy;
  logic          done;
  logic          any_sent;
`ifdef VSSSP_APPLY_STATS_EN
  logic [AW:0]   msg_count;
`endif
  logic [2:0]    dbg_state;

  logic [2*AW+77:0] all_outs;
  assign all_outs = {state_rd_addr, state_rd_en, state_wr_en, state_wr_addr,
                     msg_valid, msg_sender, msg_dist, msg_level, busy, done, any_sent};

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------- DUT
  vsssp_apply #(.NUM_NODES(NN), .ADDR_WIDTH(AW)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .start           (start),
    .level_in        (level_in),
    .state_rd_addr   (state_rd_addr),
    .state_rd_en     (state_rd_en),
    .state_rd_dist   (state_rd_dist),
    .state_rd_active (state_rd_active),
    .state_wr_en     (state_wr_en),
    .state_wr_addr   (state_wr_addr),
    .msg_valid       (msg_valid),
    .msg_ack         (msg_ack),
    .msg_sender      (msg_sender),
    .msg_dist        (msg_dist),
    .msg_level       (msg_level),
    .busy            (busy),
    .done            (done),
    .any_sent        (any_sent),
`ifdef VSSSP_APPLY_STATS_EN
    .msg_count       (msg_count),
`endif
    .o_dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------- state memory model
  logic [7:0] mem_dist   [NN];
  logic       mem_active [NN];
  logic [7:0] ld_dist    [NN];
  logic       ld_active  [NN];
  logic       ld;

  always @(posedge sys_clk) begin
    if (ld) begin
      for (int i = 0; i < NN; i++) begin
        mem_dist[i]   <= ld_dist[i];
        mem_active[i] <= ld_active[i];
      end
    end else if (state_wr_en) begin
      mem_active[state_wr_addr] <= 1'b0;
    end
    if (state_rd_en) begin
      state_rd_dist   <= mem_dist[state_rd_addr];
      state_rd_active <= mem_active[state_rd_addr];
    end
  end

  // ---------------------------------------------------------------- ack driver
  // 0: tied high, 1: random, 2: stall 5 valid cycles then ack, 3: never ack
  int ack_mode  = 0;
  int stall_cnt = 0;

  always @(negedge sys_clk) begin
    case (ack_mode)
      0: msg_ack = 1'b1;
      1: msg_ack = 1'($urandom_range(0, 1));
      2: begin
        if (msg_valid) begin
          msg_ack = (stall_cnt == 5);
          stall_cnt++;
        end else begin
          msg_ack = 1'b0;
          stall_cnt = 0;
        end
      end
      default: msg_ack = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- scoreboard / monitor
  logic [71:0] exp_q[$];     // {sender, dist, level}
  logic [AW-1:0] exp_wr_q[$];
  logic        pend;
  logic [71:0] pend_msg;
  int          vlen = 0;
  int          last_len = 0;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pend = 1'b0;
      vlen = 0;
    end else begin
      if (pend) begin
        n_checks++;
        if (msg_valid !== 1'b1 || {msg_sender, msg_dist, msg_level} !== pend_msg) begin
          n_errors++;
          $display("FAIL msg_stable: got valid=%b msg=%h, required valid=1 msg=%h",
                   msg_valid, {msg_sender, msg_dist, msg_level}, pend_msg);
        end
      end
      n_checks++;
      if (state_wr_en !== (msg_valid && msg_ack)) begin
        n_errors++;
        $display("FAIL wr_en_vs_ack: got wr_en=%b, required %b", state_wr_en, msg_valid && msg_ack);
      end
      if (msg_valid) vlen++;
      if (msg_valid && msg_ack) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL msg_unexpected: got msg=%h, required no message", {msg_sender, msg_dist, msg_level});
        end else begin
          logic [71:0] e;
          e = exp_q.pop_front();
          if ({msg_sender, msg_dist, msg_level} !== e) begin
            n_errors++;
            $display("FAIL msg_payload: got %h, required %h", {msg_sender, msg_dist, msg_level}, e);
          end
        end
        last_len = vlen;
        vlen = 0;
        pend = 1'b0;
      end else if (msg_valid) begin
        pend = 1'b1;
        pend_msg = {msg_sender, msg_dist, msg_level};
      end else begin
        pend = 1'b0;
      end
      if (state_wr_en) begin
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_errors++;
          $display("FAIL wr_unexpected: got addr=%0d, required no write", state_wr_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_wr_q.pop_front();
          if (state_wr_addr !== ea) begin
            n_errors++;
            $display("FAIL wr_addr: got %0d, required %0d", state_wr_addr, ea);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic load_mem(input logic [7:0] d[NN], input logic a[NN]);
    for (int i = 0; i < NN; i++) begin
      ld_dist[i]   = d[i];
      ld_active[i] = a[i];
    end
    @(negedge sys_clk) ld = 1'b1;
    @(negedge sys_clk) ld = 1'b0;
  endtask

  // Runs one full scan, building the expected result from the memory first.
  task automatic run_scan(input logic [31:0] level, input int mid_start, input bit done_start);
    int n_exp;
    int exp_cyc;
    int cyc;
    bit timed_out;
    n_exp = 0;
    exp_cyc = 1;
    for (int i = 0; i < NN; i++) begin
      if (mem_active[i]) begin
        int d;
        d = int'(mem_dist[i]) + 1;
        if (d > 255) d = 255;
        exp_q.push_back({32'(i), 8'(d), level});
        exp_wr_q.push_back(AW'(i));
        n_exp++;
        exp_cyc += 3;
      end else begin
        exp_cyc += 2;
      end
    end
    @(negedge sys_clk);
    start = 1'b1;
    level_in = level;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge sys_clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_after_start: got busy=%b done=%b, required busy=1 done=0", busy, done);
        end
      end
      if (mid_start != 0 && cyc == mid_start) begin
        start = 1'b1;
        level_in = level + 32'd99;
      end
      if (done === 1'b1) break;
      if (cyc > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    n_checks++;
    if (timed_out) begin
      n_errors++;
      $display("FAIL scan_timeout: got no done after %0d cycles (state %0d), required done", cyc, dbg_state);
      exp_q.delete();
      exp_wr_q.delete();
    end else begin
      if (ack_mode == 0) begin
        n_checks++;
        if (cyc != exp_cyc) begin
          n_errors++;
          $display("FAIL scan_cycles: got %0d, required %0d", cyc, exp_cyc);
        end
      end
      n_checks++;
      if (busy !== 1'b0 || any_sent !== (n_exp > 0)) begin
        n_errors++;
        $display("FAIL done_flags: got busy=%b any_sent=%b, required busy=0 any_sent=%b",
                 busy, any_sent, n_exp > 0);
      end
`ifdef VSSSP_APPLY_STATS_EN
      n_checks++;
      if (msg_count !== (AW+1)'(n_exp)) begin
        n_errors++;
        $display("FAIL msg_count: got %0d, required %0d", msg_count, n_exp);
      end
`endif
      if (done_start) begin
        start = 1'b1;
        level_in = ~level;
      end
      @(negedge sys_clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || any_sent !== (n_exp > 0)) begin
        n_errors++;
        $display("FAIL after_done: got done=%b busy=%b any_sent=%b, required 0 0 %b",
                 done, busy, any_sent, n_exp > 0);
      end
      n_checks++;
      if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
        n_errors++;
        $display("FAIL missing_traffic: got %0d msgs and %0d writes outstanding, required 0 0",
                 exp_q.size(), exp_wr_q.size());
        exp_q.delete();
        exp_wr_q.delete();
      end
      for (int i = 0; i < NN; i++) begin
        n_checks++;
        if (mem_active[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL active_cleared: node %0d got active=%b, required 0", i, mem_active[i]);
        end
      end
    end
    repeat (2) @(negedge sys_clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++;
      $display("FAIL post_reset_outputs: got %h, required 0", all_outs);
    end
`ifdef VSSSP_APPLY_STATS_EN
    n_checks++;
    if (msg_count !== '0) begin
      n_errors++;
      $display("FAIL reset_msg_count: got %0d, required 0", msg_count);
    end
`endif
  endtask

  task automatic test_all_inactive();
    logic [7:0] d[NN] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic       a[NN] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ack_mode = 0;
    load_mem(d, a);
    run_scan(32'd3, 0, 1'b0);
  endtask

  task automatic test_single_active();
    logic [7:0] d[NN] = '{8'd0, 8'd0, 8'd5, 8'd0};
    logic       a[NN] = '{1'b0, 1'b0, 1'b1, 1'b0};
    ack_mode = 0;
    load_mem(d, a);
    run_scan(32'd3, 0, 1'b0);
  endtask

  task automatic test_saturate();
    logic [7:0] d[NN] = '{8'hFE, 8'hFF, 8'h10, 8'h00};
    logic       a[NN] = '{1'b1, 1'b1, 1'b0, 1'b1};
    ack_mode = 0;
    load_mem(d, a);
    run_scan(32'hDEAD_0001, 0, 1'b0);
  endtask

  task automatic test_ack_stall();
    logic [7:0] d[NN] = '{8'd0, 8'd7, 8'd0, 8'd0};
    logic       a[NN] = '{1'b0, 1'b1, 1'b0, 1'b0};
    ack_mode = 2;
    load_mem(d, a);
    run_scan(32'd8, 0, 1'b0);
    n_checks++;
    if (last_len != 6) begin
      n_errors++;
      $display("FAIL stall_valid_len: got %0d cycles, required 6", last_len);
    end
    ack_mode = 0;
  endtask

  task automatic test_start_ignored();
    logic [7:0] d[NN] = '{8'd0, 8'd20, 8'd0, 8'd30};
    logic       a[NN] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ack_mode = 0;
    load_mem(d, a);
    // Extra start in the middle of the scan and another in the done cycle.
    run_scan(32'd7, 3, 1'b1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_in_done_restart: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] d[NN] = '{8'd0, 8'd9, 8'd0, 8'd0};
    logic       a[NN] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int w;
    ack_mode = 3;
    load_mem(d, a);
    @(negedge sys_clk);
    start = 1'b1;
    level_in = 32'd11;
    @(negedge sys_clk);
    start = 1'b0;
    w = 0;
    while (msg_valid !== 1'b1 && w < 50) begin
      @(negedge sys_clk);
      w++;
    end
    n_checks++;
    if (msg_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL send_reached: got msg_valid=%b, required 1", msg_valid);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_send_outputs: got %h, required 0", all_outs);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (mem_active[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_keeps_active: got %b, required 1", mem_active[1]);
    end
    ack_mode = 0;
    run_scan(32'd12, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d[NN];
    logic       a[NN];
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NN; i++) begin
        d[i] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) d[i] = 8'hFF;
        a[i] = 1'($urandom_range(0, 1));
      end
      ack_mode = (it % 3 == 0) ? 0 : 1;
      load_mem(d, a);
      run_scan($urandom, 0, 1'b0);
    end
    ack_mode = 0;
  endtask

`ifdef VSSSP_APPLY_STATS_EN
  task automatic test_stats();
    logic [7:0] d[NN] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic       a[NN] = '{1'b1, 1'b1, 1'b1, 1'b1};
    ack_mode = 1;
    load_mem(d, a);
    run_scan(32'd5, 0, 1'b0);
    n_checks++;
    if (msg_count !== (AW+1)'(4)) begin
      n_errors++;
      $display("FAIL stats_hold: got %0d, required 4", msg_count);
    end
    ack_mode = 0;
  endtask
`endif

  // ---------------------------------------------------------------- main
  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    level_in  = '0;
    msg_ack   = 1'b0;
    ld        = 1'b0;
    pend      = 1'b0;
    pend_msg  = '0;
    for (int i = 0; i < NN; i++) begin
      ld_dist[i]   = '0;
      ld_active[i] = 1'b0;
    end
    test_reset();
    test_all_inactive();
    test_single_active();
    test_saturate();
    test_ack_stall();
    test_start_ignored();
    test_reset_mid_send();
    test_random();
`ifdef VSSSP_APPLY_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
